fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the main control decoder.
- Holds the PC and fetches one instruction word per instruction over a request/ready handshake with instruction memory.
- Presents the instruction to the decoder and datapath as op/funct fields plus the full word, waits for the datapath to signal completion, then computes the next PC.
- Next PC is one of: sequential, branch (pcsrc) or jump.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/pc_next_logic.sv | 31 +++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: widths, opcodes and the fetch FSM state type.
package mips_pkg;

    localparam int XLEN = 32;
    localparam int OPW  = 6;

    localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPW-1:0] OP_LW    = 6'h23;
    localparam logic [OPW-1:0] OP_SW    = 6'h2B;
    localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPW-1:0] OP_J     = 6'h02;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: jump beats taken branch, which beats sequential.
// Only the low 26 instruction bits ever contribute to a target.
module pc_next_logic
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [25:0]     instr,
    input  logic            pcsrc,
    input  logic            jump,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] w_br_off;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_j_target;

    assign pc_plus4    = pc + 32'd4;
    assign w_br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign w_br_target = pc_plus4 + w_br_off;
    assign w_j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = w_j_target;
        else if (pcsrc)
            next_pc = w_br_target;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: requests one word per instruction, holds it for the
// decoder until the datapath reports completion, then advances the PC.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [OPW-1:0]  op,
    output logic [OPW-1:0]  funct,
    output logic            instr_valid,
    input  logic            pcsrc,
    input  logic            jump,
    input  logic            exec_done,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [31:0]     instr_count,
    output logic            fetch_err
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TMO_MAX  = CW'(TIMEOUT);
    localparam logic [XLEN-1:0] PC_RESET = RESET_PC & ~32'd3;

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [31:0]     r_count;
    logic [CW-1:0]   r_tmo_cnt;
    logic            r_fetch_err;
    logic [XLEN-1:0] w_next_pc;

    pc_next_logic u_pc_next (
        .pc       (r_pc),
        .instr    (r_instr[25:0]),
        .pcsrc    (pcsrc),
        .jump     (jump),
        .pc_plus4 (pc_plus4),
        .next_pc  (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH:   if (imem_ready) w_state_next = ISSUE;
            ISSUE:   if (exec_done)  w_state_next = FETCH;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (r_state == FETCH);
        instr_valid = (r_state == ISSUE);
    end

    // The timeout counter saturates so a stuck request keeps the flag set without wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc        <= PC_RESET;
            r_instr     <= '0;
            r_count     <= '0;
            r_tmo_cnt   <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ready) begin
                        r_instr   <= imem_rdata;
                        r_tmo_cnt <= '0;
                    end else if (r_tmo_cnt != TMO_MAX) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (r_tmo_cnt == TMO_MAX - 1'b1)
                            r_fetch_err <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        r_pc    <= w_next_pc;
                        r_count <= r_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign op          = r_instr[31:26];
    assign funct       = r_instr[5:0];
    assign instr_count = r_count;
    assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-instruction vector table plus hand-written
// sequences for upper-half jump, fetch timeout and reset during a pending fetch.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ready, instr_valid, pcsrc, jump, exec_done, fetch_err;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, instr_count;
    logic [5:0]  op, funct;

    logic        b_req, b_valid, b_exec_done, b_err;
    logic [31:0] b_addr, b_instr, b_pc, b_pc4, b_count;
    logic [5:0]  b_op, b_funct;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .op(op),
        .funct(funct), .instr_valid(instr_valid), .pcsrc(pcsrc), .jump(jump),
        .exec_done(exec_done), .pc(pc), .pc_plus4(pc_plus4),
        .instr_count(instr_count), .fetch_err(fetch_err)
    );

    // Second instance starts in the upper half of the address space; low PC bits must be dropped.
    fetch_unit #(.RESET_PC(32'h8000_0003), .TIMEOUT(16)) dut_hi (
        .clk(clk), .reset(reset), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ready(1'b1), .imem_rdata(32'h0800_0010), .instr(b_instr), .op(b_op),
        .funct(b_funct), .instr_valid(b_valid), .pcsrc(1'b1), .jump(1'b1),
        .exec_done(b_exec_done), .pc(b_pc), .pc_plus4(b_pc4),
        .instr_count(b_count), .fetch_err(b_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        pcsrc;
        logic        jump;
        int          ready_dly;
        int          hold;
        logic [31:0] exp_addr;
        logic [5:0]  exp_op;
        logic [5:0]  exp_funct;
        logic [31:0] exp_pc4;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h2008_0005, 0, 0, 0, 0, 32'h0000_0000, 6'h08, 6'h05, 32'h0000_0004, 32'h0000_0004};
        vecs[1]  = '{32'h0000_0020, 0, 0, 0, 0, 32'h0000_0004, 6'h00, 6'h20, 32'h0000_0008, 32'h0000_0008};
        vecs[2]  = '{32'h0000_0020, 0, 0, 2, 0, 32'h0000_0008, 6'h00, 6'h20, 32'h0000_000C, 32'h0000_000C};
        vecs[3]  = '{32'h0000_0020, 0, 0, 0, 3, 32'h0000_000C, 6'h00, 6'h20, 32'h0000_0010, 32'h0000_0010};
        vecs[4]  = '{32'h1000_FFFE, 1, 0, 0, 0, 32'h0000_0010, 6'h04, 6'h3E, 32'h0000_0014, 32'h0000_000C};
        vecs[5]  = '{32'h1000_FFFE, 0, 0, 0, 0, 32'h0000_000C, 6'h04, 6'h3E, 32'h0000_0010, 32'h0000_0010};
        vecs[6]  = '{32'h1000_FFFE, 0, 0, 0, 0, 32'h0000_0010, 6'h04, 6'h3E, 32'h0000_0014, 32'h0000_0014};
        vecs[7]  = '{32'h0800_0010, 1, 1, 0, 2, 32'h0000_0014, 6'h02, 6'h10, 32'h0000_0018, 32'h0000_0040};
        vecs[8]  = '{32'h0800_0000, 0, 1, 0, 0, 32'h0000_0040, 6'h02, 6'h00, 32'h0000_0044, 32'h0000_0000};
        vecs[9]  = '{32'h1000_FFFE, 1, 0, 0, 0, 32'h0000_0000, 6'h04, 6'h3E, 32'h0000_0004, 32'hFFFF_FFFC};
        vecs[10] = '{32'h0000_0020, 0, 0, 1, 0, 32'hFFFF_FFFC, 6'h00, 6'h20, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{32'hAC01_0004, 1, 0, 0, 0, 32'h0000_0000, 6'h2B, 6'h04, 32'h0000_0004, 32'h0000_0014};

        reset = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        pcsrc = 1'b0; jump = 1'b0; exec_done = 1'b0; b_exec_done = 1'b0;
        repeat (3) step();
        check("rst_req",   {31'd0, imem_req},    32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc",    pc,                   32'd0);
        check("rst_instr", instr,                32'd0);
        check("rst_count", instr_count,          32'd0);
        check("rst_err",   {31'd0, fetch_err},   32'd0);
        check("rst_pc_hi", b_pc,                 32'h8000_0000);

        reset = 1'b1;
        step();
        check("first_req",  {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr,         32'd0);

        // Upper-half jump with pcsrc also asserted: jump must win.
        step();
        check("hi_valid", {31'd0, b_valid}, 32'd1);
        b_exec_done = 1'b1;
        step();
        b_exec_done = 1'b0;
        check("hi_jump_pc", b_pc, 32'h8000_0040);

        for (int i = 0; i < 12; i++) begin
            $display("vector %0d: addr=%h rdata=%h pcsrc=%0b jump=%0b", i, vecs[i].exp_addr,
                     vecs[i].rdata, vecs[i].pcsrc, vecs[i].jump);
            check($sformatf("v%0d_req", i), {31'd0, imem_req}, 32'd1);
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            for (int d = 0; d < vecs[i].ready_dly; d++) step();
            imem_ready = 1'b1; imem_rdata = vecs[i].rdata;
            step();
            imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
            check($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            check($sformatf("v%0d_op", i), {26'd0, op}, {26'd0, vecs[i].exp_op});
            check($sformatf("v%0d_funct", i), {26'd0, funct}, {26'd0, vecs[i].exp_funct});
            check($sformatf("v%0d_pc4", i), pc_plus4, vecs[i].exp_pc4);
            // Stray controls while exec_done is low must change nothing.
            for (int h = 0; h < vecs[i].hold; h++) begin
                imem_ready = 1'b1; pcsrc = 1'b1; jump = 1'b1;
                step();
            end
            imem_ready = 1'b0;
            if (vecs[i].hold > 0) begin
                check($sformatf("v%0d_hold_instr", i), instr, vecs[i].rdata);
                check($sformatf("v%0d_hold_pc", i), pc, vecs[i].exp_addr);
                check($sformatf("v%0d_hold_valid", i), {31'd0, instr_valid}, 32'd1);
            end
            pcsrc = vecs[i].pcsrc; jump = vecs[i].jump; exec_done = 1'b1;
            step();
            pcsrc = 1'b0; jump = 1'b0; exec_done = 1'b0;
            check($sformatf("v%0d_next_pc", i), pc, vecs[i].exp_next);
            check($sformatf("v%0d_count", i), instr_count, 32'(i + 1));
        end

        // Fetch timeout: flag after exactly 16 unanswered FETCH cycles, request keeps pending.
        for (int t = 0; t < 15; t++) step();
        $display("timeout: 15 unanswered fetch cycles");
        check("tmo_err_15", {31'd0, fetch_err}, 32'd0);
        step();
        check("tmo_err_16", {31'd0, fetch_err}, 32'd1);
        check("tmo_req_16", {31'd0, imem_req},  32'd1);
        repeat (5) step();
        check("tmo_req_21", {31'd0, imem_req},  32'd1);
        imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
        step();
        imem_ready = 1'b0;
        check("tmo_valid", {31'd0, instr_valid}, 32'd1);
        check("tmo_op",    {26'd0, op},          32'h08);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check("tmo_pc",    pc,                   32'h0000_0018);
        check("tmo_count", instr_count,          32'd13);
        check("tmo_sticky", {31'd0, fetch_err},  32'd1);

        // Reset while fetching, with imem_ready on the reset edge: the word must be dropped.
        $display("reset during pending fetch at pc=%h", pc);
        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        reset = 1'b1; imem_ready = 1'b0;
        check("mid_rst_req",   {31'd0, imem_req},    32'd0);
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_instr", instr,                32'd0);
        check("mid_rst_pc",    pc,                   32'd0);
        check("mid_rst_count", instr_count,          32'd0);
        check("mid_rst_err",   {31'd0, fetch_err},   32'd0);
        step();
        check("mid_rst_req2",   {31'd0, imem_req},    32'd1);
        check("mid_rst_valid2", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_addr2",  imem_addr,            32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
